down_counter4: RTL
==================

// Module: down_counter4
// PURPOSE
//  Loadable, cascadable down-counter: the decrementing counterpart of the
//  4-bit single-bit incrementer. Subtracts borrow-in (bin) from a WIDTH-bit
//  count each enabled clock, exposes a ripple borrow-out for chaining stages,
//  and runs a load/run/done sequence so it can serve as a countdown timer
//  for the game/control logic.
// PARAMETERS
//  WIDTH        4  count width in bits
//  AUTO_RELOAD  0  1: on reaching zero in RUN, reload the last loaded value and stay in RUN
// PORTS
//  clk       in   1      rising-edge clock, single clock domain
//  rst       in   1      synchronous reset, active-high
//  load      in   1      load load_val this cycle; starts a countdown
//  load_val  in   WIDTH  value to load
//  en        in   1      count enable
//  bin       in   1      borrow-in; decrement by 1 when en & bin & ~load
//  count     out  WIDTH  current count (registered)
//  bout      out  1      borrow-out, combinational: en & bin & ~load & (count==0)
//  busy      out  1      1 while state==RUN (registered)
//  done      out  1      one-cycle pulse, registered, countdown completed
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): count=0, state=IDLE, busy=0, done=0, reload reg=0.
//    rst overrides load and decrement; reset mid-countdown abandons it, no done.
//  - Priority per edge: rst > load > decrement > hold.
//  - States: IDLE, RUN. busy = (state==RUN).
//  - load=1: count<=load_val, reload reg<=load_val; load_val!=0 -> RUN, done<=0;
//    load_val==0 -> IDLE, done<=1 (immediate completion). Legal in any state;
//    load during RUN restarts the countdown, no done for the aborted one.
//  - dec = en & bin & ~load. dec: count<=count-1 modulo 2^WIDTH; otherwise hold.
//  - Terminal event: state==RUN & dec & count==1.
//      AUTO_RELOAD=0: count<=0, state<=IDLE, done<=1.
//      AUTO_RELOAD=1: count<=reload reg, stay RUN, done<=1.
//  - done is 1 for exactly the cycle after a terminal event or zero-load; 0 else.
//  - Decrement in IDLE is allowed (free-running): count==0 wraps to 2^WIDTH-1,
//    state stays IDLE, done stays 0; bout=1 during that cycle.
//  - count==0 in RUN is unreachable (AUTO_RELOAD=0 leaves RUN; reload reg is
//    nonzero whenever RUN is entered).
//  - en=0 or bin=0: count, state frozen; done still drops after its one cycle.
//  - bout never asserts when load=1; latency count->bout is zero cycles,
//    so N stages chain bin(k+1)=bout(k) with shared en.
//  - Latency: load to count visible 1 cycle; terminal decrement to done 1 cycle.
// TESTING
//  1. rst; load=1 load_val=5; then en=bin=1 -> count 5,4,3,2,1,0; busy=1 for
//     5..1, at count=0: busy=0, done=1 for one cycle only; bout=0 throughout.
//  2. IDLE, count=0, en=bin=1 one cycle -> bout=1 that cycle; count=15 next,
//     done=0, busy=0.
//  3. load=1 load_val=0 -> next cycle count=0, busy=0, done=1; following cycle done=0.
//  4. RUN at count=2, load=1 load_val=9 with en=bin=1 -> bout=0, count=9,
//     busy=1, no done pulse.
//  5. RUN at count=3, rst=1 with load=1 load_val=7 -> count=0, busy=0, done=0.
//  6. AUTO_RELOAD=1, load 3, en=bin=1 -> count 3,2,1,3,2,1; done=1 each cycle
//     count returns to 3 after 1; busy stays 1; en=0 freezes count.

Source files
------------

// File: rtl/down_counter4.sv
// down_counter4: loadable, cascadable down-counter with a load/run/done
// countdown sequence. Each enabled cycle subtracts the borrow-in from the
// count. A combinational borrow-out lets several stages be chained. A
// one-cycle done pulse marks the end of a countdown.
module down_counter4 #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             bin,
    output logic [WIDTH-1:0] count,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload_val;

    logic dec;
    logic count_is_zero;
    logic count_is_one;
    logic terminal;

    // Load has priority over counting, so a decrement only happens when
    // no load is requested. Borrow-out is kept combinational so that a
    // chain of stages ripples within one cycle.
    assign dec           = en & bin & ~load;
    assign count_is_zero = (count == '0);
    assign count_is_one  = (count == WIDTH'(1));
    assign terminal      = (state == RUN) & dec & count_is_one;
    assign bout          = dec & count_is_zero;

    // Count, state, reload value and the registered busy/done flags.
    // The order of priority is reset, then load, then the terminal
    // decrement, then a plain decrement. When none of these applies,
    // the registers hold their values. done defaults low so it lasts
    // exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            reload_val <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                count      <= load_val;
                reload_val <= load_val;
                if (load_val != '0) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end else if (terminal) begin
                done <= 1'b1;
                if (AUTO_RELOAD) begin
                    count <= reload_val;
                end else begin
                    count <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else if (dec) begin
                count <= count - WIDTH'(1);
            end
        end
    end

endmodule
